// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory and the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Fetch requester
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic [DATA_W-1:0] o_if_rdata;
    // Data requester
    logic              i_dm_req;
    logic              i_dm_we;
    logic [ADDR_W-1:0] i_dm_addr;
    logic [DATA_W-1:0] i_dm_wdata;
    logic [3:0]        i_dm_be;
    logic              o_dm_gnt;
    logic              o_dm_rvalid;
    logic [DATA_W-1:0] o_dm_rdata;
    // Memory side
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [3:0]        o_mem_be;
    logic [DATA_W-1:0] i_mem_rdata;
    // Status
    logic              o_busy;

    // Arbiter side
    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
        output o_dm_gnt, o_dm_rvalid, o_dm_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  i_mem_rdata,
        output o_busy
    );

    // Requester / memory side
    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
        input  o_dm_gnt, o_dm_rvalid, o_dm_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output i_mem_rdata,
        input  o_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between a fetch port and a data port.
// Data wins by default; fetch wins after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    mem_port_arbiter_if.slave    bus
);
    localparam int unsigned LAT_W    = 3;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic                  owner_dm_q, owner_dm_d;
    logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     dm_rdata_q, dm_rdata_d;

    logic grant_ok;
    logic starved;
    logic dm_win;
    logic if_win;
    logic rd_grant;

    // Arbitration, memory command, next state and status outputs
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        owner_dm_d   = owner_dm_q;
        starve_cnt_d = starve_cnt_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;

        bus.o_mem_en    = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_be    = 4'h0;

        grant_ok = ((state_q == IDLE) || (state_q == RESP)) && !i_reset;
        starved  = (starve_cnt_q == STARVE_W'(STARVE_MAX));
        dm_win   = grant_ok && bus.i_dm_req && !(bus.i_if_req && starved);
        if_win   = grant_ok && bus.i_if_req && !dm_win;
        rd_grant = if_win || (dm_win && !bus.i_dm_we);

        bus.o_if_gnt = if_win;
        bus.o_dm_gnt = dm_win;

        // Drive the winner's command straight onto the memory port
        if (dm_win) begin
            bus.o_mem_en    = 1'b1;
            bus.o_mem_we    = bus.i_dm_we;
            bus.o_mem_addr  = bus.i_dm_addr;
            bus.o_mem_wdata = bus.i_dm_we ? bus.i_dm_wdata : '0;
            bus.o_mem_be    = bus.i_dm_we ? bus.i_dm_be : 4'hF;
        end else if (if_win) begin
            bus.o_mem_en    = 1'b1;
            bus.o_mem_addr  = bus.i_if_addr;
            bus.o_mem_be    = 4'hF;
        end

        // Fetch loss counter: counts only data grants that beat a waiting fetch
        if (!bus.i_if_req || if_win) begin
            starve_cnt_d = '0;
        end else if (dm_win && !starved) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end

        case (state_q)
            IDLE, RESP: begin
                if (rd_grant) begin
                    state_d    = RD_WAIT;
                    lat_cnt_d  = LAT_W'(RD_LAT - 1);
                    owner_dm_d = dm_win;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_dm_q) begin
                        dm_rdata_d = bus.i_mem_rdata;
                    end else begin
                        if_rdata_d = bus.i_mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        bus.o_if_rvalid = (state_q == RESP) && !owner_dm_q;
        bus.o_dm_rvalid = (state_q == RESP) && owner_dm_q;
        bus.o_busy      = (state_q == RD_WAIT) || ((state_q == RESP) && !rd_grant);
        bus.o_if_rdata  = if_rdata_q;
        bus.o_dm_rdata  = dm_rdata_q;
    end

    // State, latency counter, starvation counter and read data registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            owner_dm_q   <= 1'b0;
            starve_cnt_q <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            owner_dm_q   <= owner_dm_d;
            starve_cnt_q <= starve_cnt_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end
endmodule
